// File: rtl/multibyte_add_seq_pkg.sv
// Shared constants and types for the byte-serial wide add/subtract sequencer.
package multibyte_add_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Width of the byte index counter; kept at least one bit wide.
   function automatic int idx_width(input int nbytes);
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

endpackage

// File: rtl/multibyte_add_seq_if.sv
// START/BUSY/DONE handshake plus operand and result bus of the wide add/subtract sequencer.
interface multibyte_add_seq_if #(
   parameter int NBYTES = 4
);
   import multibyte_add_seq_pkg::*;

   localparam int W = BYTE_W * NBYTES;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] y;
   logic         c;
   logic         v;
   logic         z;
   logic         n;

   modport master (
      output start, sub, a, b,
      input  busy, done, y, c, v, z, n
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, y, c, v, z, n
   );

endinterface

// File: rtl/multibyte_add_seq_adder.sv
// Existing 8-bit ripple-carry adder shared by the sequencer, one byte slice per clock.
module adder
   import multibyte_add_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              ci,
   output logic [BYTE_W-1:0] y,
   output logic              c,
   output logic              v
);

   logic [BYTE_W:0] cy;

   always_comb begin
      cy[0] = ci;
      for (int i = 0; i < BYTE_W; i++) begin
         y[i]    = a[i] ^ b[i] ^ cy[i];
         cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
      end
      c = cy[BYTE_W];
      v = cy[BYTE_W] ^ cy[BYTE_W-1];
   end

endmodule

// File: rtl/multibyte_add_seq.sv
// Wide add/subtract on one shared 8-bit adder, one byte per clock LSB first,
// with the inter-byte carry held in a register and C/V/Z/N flags on completion.
module multibyte_add_seq
   import multibyte_add_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   multibyte_add_seq_if.slave  bus
);

   localparam int                W     = BYTE_W * NBYTES;
   localparam int                IDX_W = idx_width(NBYTES);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NBYTES - 1);

   state_t            state, state_nxt;
   logic              accept, last;

   logic [IDX_W-1:0]  idx;
   logic              carry;
   logic              sub_lat;
   logic [W-1:0]      a_lat, b_lat;
   logic [W-1:0]      y_r, y_nxt;
   logic              c_r, v_r, z_r, n_r;

   logic [BYTE_W-1:0] a_byte, bx_byte, sum;
   logic              sum_c;
   logic              adder_v_unused;

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assignment first so no path through the case leaves
   // state_nxt unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last)      state_nxt = FIN;
         FIN:     state_nxt = bus.start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FIN accepts a new START just like IDLE, giving back-to-back operations.
   always_comb begin
      accept = bus.start && ((state == IDLE) || (state == FIN));
      last   = (state == RUN) && (idx == LAST);
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == FIN);
   assign bus.y    = y_r;
   assign bus.c    = c_r;
   assign bus.v    = v_r;
   assign bus.z    = z_r;
   assign bus.n    = n_r;

   // Byte slice i of the latched operands; subtraction inverts B and seeds carry with 1.
   always_comb begin
      a_byte  = a_lat[int'(idx)*BYTE_W +: BYTE_W];
      bx_byte = b_lat[int'(idx)*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_lat}};
      y_nxt   = y_r;
      y_nxt[int'(idx)*BYTE_W +: BYTE_W] = sum;
   end

   adder u_adder (
      .a  (a_byte),
      .b  (bx_byte),
      .ci (carry),
      .y  (sum),
      .c  (sum_c),
      .v  (adder_v_unused)
   );

   // NOTE: the operand and result registers are plain flops, not a memory
   // array, so they take the asynchronous reset like every other state bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         carry   <= 1'b0;
         sub_lat <= 1'b0;
         a_lat   <= '0;
         b_lat   <= '0;
         y_r     <= '0;
         c_r     <= 1'b0;
         v_r     <= 1'b0;
         z_r     <= 1'b0;
         n_r     <= 1'b0;
      end else if (accept) begin
         idx     <= '0;
         carry   <= bus.sub;
         sub_lat <= bus.sub;
         a_lat   <= bus.a;
         b_lat   <= bus.b;
         y_r     <= '0;
      end else if (state == RUN) begin
         y_r   <= y_nxt;
         carry <= sum_c;
         idx   <= last ? '0 : idx + 1'b1;
         if (last) begin
            c_r <= sum_c;
            v_r <= (a_lat[W-1] == bx_byte[BYTE_W-1]) && (sum[BYTE_W-1] != a_lat[W-1]);
            z_r <= (y_nxt == '0);
            n_r <= y_nxt[W-1];
         end
      end
   end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed-vector bench for multibyte_add_seq with NBYTES = 4.
module tb_multibyte_add_seq;
   import multibyte_add_seq_pkg::*;

   localparam int NB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   multibyte_add_seq_if #(.NBYTES(NB)) bus ();

   multibyte_add_seq #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        sub;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic [3:0]  f;   // {c, v, z, n}
   } vec_t;

   // Issue one operation and count cycles from the START edge to the DONE cycle (-1 on timeout).
   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
      @(negedge clk);
      bus.start = 1'b1; bus.sub = s; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 1; busy_cnt = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         if (bus.busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (bus.done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      total++; if (bus.y !== 32'h0) begin bad++; $display("FAIL reset_y got=%h want=0", bus.y); end
      total++; if ({bus.c, bus.v, bus.z, bus.n} !== 4'b0000)
         begin bad++; $display("FAIL reset_flags got=%b want=0000", {bus.c, bus.v, bus.z, bus.n}); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_add();
      vec_t t[3];
      int   lat, bc;
      t[0] = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 4'b0000};
      t[1] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
      t[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
      for (int i = 0; i < 3; i++) begin
         do_op(t[i].sub, t[i].a, t[i].b, lat, bc);
         total++; if (lat != 5) begin bad++; $display("FAIL add%0d_latency got=%0d want=5", i, lat); end
         total++; if (bc != 4) begin bad++; $display("FAIL add%0d_busy_cycles got=%0d want=4", i, bc); end
         total++; if (bus.y !== t[i].y) begin bad++; $display("FAIL add%0d_y got=%h want=%h", i, bus.y, t[i].y); end
         total++; if ({bus.c, bus.v, bus.z, bus.n} !== t[i].f)
            begin bad++; $display("FAIL add%0d_flags got=%b want=%b", i, {bus.c, bus.v, bus.z, bus.n}, t[i].f); end
      end
   endtask

   task automatic test_sub();
      vec_t t[3];
      int   lat, bc;
      t[0] = '{1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1010};
      t[1] = '{1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0001};
      t[2] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100};
      for (int i = 0; i < 3; i++) begin
         do_op(t[i].sub, t[i].a, t[i].b, lat, bc);
         total++; if (lat != 5) begin bad++; $display("FAIL sub%0d_latency got=%0d want=5", i, lat); end
         total++; if (bus.y !== t[i].y) begin bad++; $display("FAIL sub%0d_y got=%h want=%h", i, bus.y, t[i].y); end
         total++; if ({bus.c, bus.v, bus.z, bus.n} !== t[i].f)
            begin bad++; $display("FAIL sub%0d_flags got=%b want=%b", i, {bus.c, bus.v, bus.z, bus.n}, t[i].f); end
      end
   endtask

   task automatic test_start_ignored();
      @(negedge clk);
      bus.start = 1'b1; bus.sub = 1'b0; bus.a = 32'h12345678; bus.b = 32'h11111111;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.sub = 1'b1; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b want=1", bus.busy); end
      repeat (2) begin @(posedge clk); #1; end
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL ign_done got=%b want=1", bus.done); end
      total++; if (bus.y !== 32'h23456789) begin bad++; $display("FAIL ign_y got=%h want=23456789", bus.y); end
      total++; if ({bus.c, bus.v, bus.z, bus.n} !== 4'b0000)
         begin bad++; $display("FAIL ign_flags got=%b want=0000", {bus.c, bus.v, bus.z, bus.n}); end
      @(posedge clk); #1;
      total++; if ({bus.busy, bus.done} !== 2'b00)
         begin bad++; $display("FAIL ign_idle got=%b want=00", {bus.busy, bus.done}); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      @(negedge clk);
      bus.start = 1'b1; bus.sub = 1'b0; bus.a = 32'h00000001; bus.b = 32'h00000002;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b want=1", bus.done); end
      total++; if (bus.y !== 32'h00000003) begin bad++; $display("FAIL b2b_y1 got=%h want=00000003", bus.y); end
      bus.start = 1'b1; bus.sub = 1'b1; bus.a = 32'h00000010; bus.b = 32'h00000020;
      @(posedge clk); #1;
      bus.start = 1'b0;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap got=%b want=1", bus.busy); end
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      total++; if (cyc != 5) begin bad++; $display("FAIL b2b_latency got=%0d want=5", cyc); end
      total++; if (bus.y !== 32'hFFFFFFF0) begin bad++; $display("FAIL b2b_y2 got=%h want=fffffff0", bus.y); end
      total++; if ({bus.c, bus.v, bus.z, bus.n} !== 4'b0001)
         begin bad++; $display("FAIL b2b_flags got=%b want=0001", {bus.c, bus.v, bus.z, bus.n}); end
   endtask

   task automatic test_reset_abort();
      int done_seen, lat, bc;
      @(negedge clk);
      bus.start = 1'b1; bus.sub = 1'b0; bus.a = 32'h01010101; bus.b = 32'h02020202;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      total++; if (bus.y !== 32'h00000303) begin bad++; $display("FAIL abort_partial_y got=%h want=00000303", bus.y); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({bus.busy, bus.done} !== 2'b00)
         begin bad++; $display("FAIL abort_ctrl got=%b want=00", {bus.busy, bus.done}); end
      total++; if (bus.y !== 32'h0) begin bad++; $display("FAIL abort_y got=%h want=0", bus.y); end
      total++; if ({bus.c, bus.v, bus.z, bus.n} !== 4'b0000)
         begin bad++; $display("FAIL abort_flags got=%b want=0000", {bus.c, bus.v, bus.z, bus.n}); end
      done_seen = 0;
      repeat (2) begin @(posedge clk); #1; if (bus.done === 1'b1) done_seen++; end
      @(negedge clk); rst_n = 1'b1;
      repeat (6) begin @(posedge clk); #1; if (bus.done === 1'b1) done_seen++; end
      total++; if (done_seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_seen); end
      do_op(1'b1, 32'h00000100, 32'h00000001, lat, bc);
      total++; if (lat != 5) begin bad++; $display("FAIL fresh_latency got=%0d want=5", lat); end
      total++; if (bus.y !== 32'h000000FF) begin bad++; $display("FAIL fresh_y got=%h want=000000ff", bus.y); end
      total++; if ({bus.c, bus.v, bus.z, bus.n} !== 4'b1000)
         begin bad++; $display("FAIL fresh_flags got=%b want=1000", {bus.c, bus.v, bus.z, bus.n}); end
   endtask

   task automatic test_idle_hold();
      repeat (3) begin @(posedge clk); #1; end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hold_done got=%b want=0", bus.done); end
      total++; if (bus.y !== 32'h000000FF) begin bad++; $display("FAIL hold_y got=%h want=000000ff", bus.y); end
      total++; if ({bus.c, bus.v, bus.z, bus.n} !== 4'b1000)
         begin bad++; $display("FAIL hold_flags got=%b want=1000", {bus.c, bus.v, bus.z, bus.n}); end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      test_reset();
      test_add();
      test_sub();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      test_idle_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Multi-cycle sequencer that performs wide add/subtract on a single shared 8-bit ripple adder, processing one byte per clock from LSB to MSB.
- The byte-to-byte carry is held in a register between cycles.
- Sits between the register file/ALU control and the existing 8-bit adder block; computes the wide result plus C/V/Z/N flags.
- Provides a START/BUSY/DONE handshake to the controlling FSM.

Parameters:
- NBYTES, 4, number of byte slices; operand width W = 8*NBYTES; legal range 2..8.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE or FIN.
- SUB  input  1  0 = A+B, 1 = A-B; latched with START.
- A  input  W  operand A; latched with START.
- B  input  W  operand B; latched with START.
- BUSY  output  1  high while bytes are being processed.
- DONE  output  1  one-cycle pulse when Y and flags become valid.
- Y  output  W  result; held until the next accepted START.
- C  output  1  final carry out; for SUB, 1 = no borrow.
- V  output  1  signed overflow.
- Z  output  1  Y == 0.
- N  output  1  Y[W-1].

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE, byte index = 0, carry register = 0.
  - Operand registers, Y, C, V, Z, N, BUSY and DONE all = 0.
  - Reset asserted mid-operation aborts immediately; no DONE is generated.
- States: IDLE, RUN, FIN.
- IDLE:
  - BUSY = 0, DONE = 0.
  - START = 1 at an edge: latch A, B, SUB; index <= 0; carry <= SUB; Y <= 0; state <= RUN.
- RUN (BUSY = 1), for each cycle at byte index i:
  - Adder inputs: A_lat byte i, (B_lat byte i XOR {8{SUB_lat}}), CI = carry register.
  - At the edge: Y byte i <= adder sum; carry <= adder carry out; index <= i+1.
  - When i = NBYTES-1, the same edge also:
    - sets C <= adder carry out;
    - sets V <= (A_lat[W-1] == Bx[W-1]) AND (sum MSB != A_lat[W-1]), where Bx = B after the SUB inversion;
    - updates Z and N from the final Y;
    - sets state <= FIN.
  - RUN lasts exactly NBYTES cycles.
  - START is ignored throughout RUN; latched operands do not change.
- FIN:
  - DONE = 1 and BUSY = 0 for exactly one cycle.
  - Without START: state <= IDLE.
  - With START = 1: behaves as an IDLE accept (new operands latched, state <= RUN). This allows back-to-back operations with no dead cycle.
- Latency: START sampled at edge k → BUSY high in cycles k+1..k+NBYTES → DONE high in cycle k+NBYTES+1.
- Throughput: one operation per NBYTES+1 cycles.
- Output timing:
  - Y bytes update progressively during RUN, so Y is valid only from the DONE cycle onward.
  - C/V/Z/N change only at the final RUN edge.
  - Y and flags are held unchanged in IDLE.
- V is computed in this block from registered sign bits; the sub-adder's own V output is left unconnected.
- All arithmetic is modulo 2^W; no saturation.

Decomposition:
- Shared package/header:
  - state encoding constants: IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  - byte width constant 8.
- Sub-module: one instance of the existing 8-bit ripple adder `adder` (A, B, CI → Y, C).
- Byte selection and write-back are done with index-based part-selects in this block.
- No other sub-modules.

Test Plan (NBYTES = 4):
- ADD 0x000000FF + 0x00000001 → Y = 0x00000100, C = 0, V = 0, Z = 0, N = 0. BUSY high for 4 cycles; DONE exactly in cycle 5 after the START edge.
- ADD 0x7FFFFFFF + 0x00000001 → Y = 0x80000000, V = 1, N = 1, C = 0, Z = 0.
- ADD 0xFFFFFFFF + 0x00000001 → Y = 0x00000000, C = 1, Z = 1, V = 0, N = 0.
- Subtract cases:
  - SUB 0x00000005 - 0x00000005 → Y = 0, Z = 1, C = 1, V = 0.
  - SUB 0x00000000 - 0x00000001 → Y = 0xFFFFFFFF, C = 0, N = 1, V = 0.
- Control corner cases:
  - START pulsed again during RUN with different operands → ignored; the first result completes unchanged.
  - START held high in the FIN cycle → second operation begins, with its DONE 5 cycles later.
  - RST_N pulled low at RUN index 2 → all outputs immediately 0, state IDLE, no DONE. A fresh START afterwards produces the correct result.
